// File: rtl/alu_op_sequencer.sv
// Multi-cycle sequencer around an external 16-bit ALU: operand fetch,
// execute, result writeback and PSR update over a 4-state FSM.
module alu_op_sequencer #(
  parameter int DW = 16,
  parameter int NREGS = 16,
  localparam int AW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [4:0]    cmd_opcode,
  input  logic [AW-1:0] cmd_rdest,
  input  logic [AW-1:0] cmd_rsrc,
  input  logic [DW-1:0] cmd_imm,
  input  logic          cmd_use_imm,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [4:0]    alu_opcode,
  input  logic [DW-1:0] alu_c,
  input  logic [4:0]    alu_flags,
  output logic [4:0]    psr,
  output logic          done,
  output logic          err,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam logic [4:0] OP_AND   = 5'b00001;
  localparam logic [4:0] OP_OR    = 5'b00010;
  localparam logic [4:0] OP_XOR   = 5'b00011;
  localparam logic [4:0] OP_NOT   = 5'b00100;
  localparam logic [4:0] OP_ADD   = 5'b00101;
  localparam logic [4:0] OP_ADDU  = 5'b00110;
  localparam logic [4:0] OP_ADDC  = 5'b00111;
  localparam logic [4:0] OP_SUB   = 5'b01001;
  localparam logic [4:0] OP_CMP   = 5'b01011;
  localparam logic [4:0] OP_LSH   = 5'b01100;
  localparam logic [4:0] OP_ADDCU = 5'b01111;
  localparam logic [4:0] OP_RSH   = 5'b10011;
  localparam logic [4:0] OP_ARSH  = 5'b10111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [4:0]    r_op;
  logic [AW-1:0] r_rdest;
  logic [AW-1:0] r_rsrc;
  logic [DW-1:0] r_imm;
  logic          r_use_imm;

  logic [DW-1:0] r_opa;
  logic [DW-1:0] r_opb;
  logic [4:0]    r_aluop;
  logic [DW-1:0] r_res;
  logic [4:0]    r_flg;
  logic [4:0]    r_psr;

  logic [DW-1:0] r_rf [NREGS];

  logic w_hs;
  logic w_sup;
  logic w_wen;
  logic w_pen;
  logic w_rf_wr;
  logic w_psr_wr;

  // Opcode classes: supported, writes RF, updates PSR
  always_comb begin
    w_sup = 1'b0;
    w_wen = 1'b0;
    w_pen = 1'b0;
    case (r_op)
      OP_ADD, OP_ADDC, OP_SUB: begin
        w_sup = 1'b1;
        w_wen = 1'b1;
        w_pen = 1'b1;
      end
      OP_CMP: begin
        w_sup = 1'b1;
        w_pen = 1'b1;
      end
      OP_ADDU, OP_ADDCU, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_LSH, OP_RSH,
      OP_ARSH: begin
        w_sup = 1'b1;
        w_wen = 1'b1;
      end
      default: begin
        w_sup = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cmd_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    w_hs      = 1'b0;
    w_rf_wr   = 1'b0;
    w_psr_wr  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_hs   = 1'b1;
          w_next = S_READ;
        end
      end
      S_READ: w_next = S_EXEC;
      S_EXEC: w_next = S_WRITE;
      S_WRITE: begin
        done     = 1'b1;
        err      = ~w_sup;
        w_rf_wr  = w_wen;
        w_psr_wr = w_pen;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= '0;
      r_rdest   <= '0;
      r_rsrc    <= '0;
      r_imm     <= '0;
      r_use_imm <= 1'b0;
    end else if (w_hs) begin
      r_op      <= cmd_opcode;
      r_rdest   <= cmd_rdest;
      r_rsrc    <= cmd_rsrc;
      r_imm     <= cmd_imm;
      r_use_imm <= cmd_use_imm;
    end
  end

  // Operand registers feed the ALU directly so its inputs stay stable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_aluop <= '0;
    end else if (r_state == S_READ) begin
      r_opa   <= r_rf[r_rdest];
      r_opb   <= r_use_imm ? r_imm : r_rf[r_rsrc];
      r_aluop <= r_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_res <= '0;
      r_flg <= '0;
    end else if (r_state == S_EXEC) begin
      r_res <= alu_c;
      r_flg <= alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_rf_wr) begin
      r_rf[r_rdest] <= r_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         r_psr <= '0;
    else if (w_psr_wr) r_psr <= r_flg;
  end

  assign alu_a      = r_opa;
  assign alu_b      = r_opb;
  assign alu_opcode = r_aluop;
  assign psr        = r_psr;
  assign dbg_data   = r_rf[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: behavioural ALU stub,
// reference RF/PSR model, queued expectations checked by a monitor.
module tb_alu_op_sequencer;

  localparam logic [4:0] ADD   = 5'b00101;
  localparam logic [4:0] ADDU  = 5'b00110;
  localparam logic [4:0] ADDC  = 5'b00111;
  localparam logic [4:0] ADDCU = 5'b01111;
  localparam logic [4:0] SUB   = 5'b01001;
  localparam logic [4:0] CMP   = 5'b01011;
  localparam logic [4:0] AND_  = 5'b00001;
  localparam logic [4:0] OR_   = 5'b00010;
  localparam logic [4:0] XOR_  = 5'b00011;
  localparam logic [4:0] NOT_  = 5'b00100;
  localparam logic [4:0] LSH   = 5'b01100;
  localparam logic [4:0] RSH   = 5'b10011;
  localparam logic [4:0] ARSH  = 5'b10111;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_opcode;
  logic [3:0]  cmd_rdest;
  logic [3:0]  cmd_rsrc;
  logic [15:0] cmd_imm;
  logic        cmd_use_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done;
  logic        err;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_rdest(cmd_rdest),
    .cmd_rsrc(cmd_rsrc), .cmd_imm(cmd_imm),
    .cmd_use_imm(cmd_use_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_c(alu_c), .alu_flags(alu_flags),
    .psr(psr), .done(done), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU stub: returns {C,L,F,Z,N, result}
  function automatic logic [20:0] alu_f(input logic [4:0] op,
                                        input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] c;
    logic cf, lf, ff;
    cf = 1'b0; lf = 1'b0; ff = 1'b0; c = '0;
    case (op)
      ADD, ADDU, ADDC, ADDCU: begin
        s = {1'b0, a} + {1'b0, b};
        c = s[15:0]; cf = s[16];
        ff = (a[15] == b[15]) && (c[15] != a[15]);
      end
      SUB: begin
        c = a - b; cf = a < b;
        ff = (a[15] != b[15]) && (c[15] != a[15]);
      end
      CMP: begin
        c = a - b;
        return {1'b0, a < b, 1'b0, a == b,
                $signed(a) < $signed(b), c};
      end
      AND_: c = a & b;
      OR_:  c = a | b;
      XOR_: c = a ^ b;
      NOT_: c = ~a;
      LSH:  c = (b >= 16) ? 16'h0 : a << b[3:0];
      RSH:  c = (b >= 16) ? 16'h0 : a >> b[3:0];
      ARSH: c = (b >= 16) ? {16{a[15]}}
                          : 16'($signed(a) >>> b[3:0]);
      default: return {5'b11111, 16'hDEAD};
    endcase
    return {cf, lf, ff, c == 16'h0, c[15], c};
  endfunction

  always_comb {alu_flags, alu_c} = alu_f(alu_opcode, alu_a, alu_b);

  typedef struct {
    int         cyc;
    logic       err;
    logic [3:0] rd;
    logic [15:0] val;
    logic [4:0] psr;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  logic [15:0] ref_rf [16];
  logic [4:0]  ref_psr;
  int nchk = 0;
  int nerr = 0;
  int last_hs = 0;
  bit chk_next = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_rf[i] = '0;
    ref_psr = '0;
  endtask

  // Reference model: apply the command's architectural effect
  task automatic push_exp(input logic [4:0] op, input logic [3:0] rd,
                          input logic [3:0] rs, input logic [15:0] imm,
                          input bit ui);
    exp_t e;
    logic [15:0] b;
    logic [20:0] r;
    bit sup;
    sup = op inside {ADD, ADDU, ADDC, ADDCU, SUB, CMP, AND_, OR_,
                     XOR_, NOT_, LSH, RSH, ARSH};
    b = ui ? imm : ref_rf[rs];
    r = alu_f(op, ref_rf[rd], b);
    if (sup && op != CMP) ref_rf[rd] = r[15:0];
    if (op inside {ADD, ADDC, SUB, CMP}) ref_psr = r[20:16];
    e.cyc = cyc + 3;
    e.err = !sup;
    e.rd  = rd;
    e.val = ref_rf[rd];
    e.psr = ref_psr;
    q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the handshake
  task automatic send(input logic [4:0] op, input logic [3:0] rd,
                      input logic [3:0] rs, input logic [15:0] imm,
                      input bit ui, input bit gap);
    int n = 0;
    cmd_opcode = op; cmd_rdest = rd; cmd_rsrc = rs;
    cmd_imm = imm; cmd_use_imm = ui; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("handshake_timeout", {31'b0, cmd_ready}, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (gap) chk("hs_spacing", cyc - last_hs, 32'd4);
    last_hs = cyc;
    push_exp(op, rd, rs, imm, ui);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    while ((q.size() != 0 || chk_next) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0 || chk_next)
      chk("drain_timeout", q.size(), 32'd0);
  endtask

  logic [4:0] ops [13];

  initial begin
    ops = '{ADD, ADDU, ADDC, ADDCU, SUB, CMP, AND_, OR_,
            XOR_, NOT_, LSH, RSH, ARSH};
    reset = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0;
    cmd_rdest = '0; cmd_rsrc = '0; cmd_imm = '0;
    cmd_use_imm = 1'b0; dbg_addr = '0;
    ref_reset();
    fork
      forever begin
        @(negedge clk);
        if (chk_next) begin
          chk("wb_data", dbg_data, cur.val);
          chk("psr", psr, cur.psr);
          chk_next = 0;
        end
        if (done) begin
          if (q.size() == 0) begin
            chk("spurious_done", done, 0);
          end else begin
            cur = q.pop_front();
            chk("done_cycle", cyc, cur.cyc);
            chk("err", err, cur.err);
            dbg_addr = cur.rd;
            chk_next = 1;
          end
        end else if (err) begin
          chk("err_without_done", err, 0);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_psr", psr, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_opcode, 0);
    chk("rst_rf0", dbg_data, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", cmd_ready, 1);

    send(ADD, 4'd1, 4'd0, 16'd5, 1, 0);
    drain();
    chk("t1_psr", psr, 5'b00000);

    send(AND_, 4'd2, 4'd0, 16'h0, 1, 0);
    send(OR_, 4'd2, 4'd0, 16'h7FFF, 1, 0);
    send(ADD, 4'd2, 4'd0, 16'h1, 1, 0);
    drain();
    chk("t2_psr", psr, 5'b00101);

    send(OR_, 4'd3, 4'd0, 16'h4, 1, 0);
    send(CMP, 4'd3, 4'd0, 16'h4, 1, 0);
    drain();
    chk("t3_cmp_psr", psr, 5'b00010);
    send(XOR_, 4'd3, 4'd3, 16'hFFFF, 0, 0);
    drain();
    chk("t3_xor_psr", psr, 5'b00010);

    send(5'b00000, 4'd2, 4'd0, 16'h1234, 1, 0);
    drain();
    chk("t4_psr", psr, 5'b00010);

    send(ADDU, 4'd6, 4'd0, 16'd3, 1, 0);
    send(ADDU, 4'd6, 4'd6, 16'd0, 0, 1);
    send(SUB, 4'd6, 4'd0, 16'd1, 1, 1);
    drain();

    send(OR_, 4'd4, 4'd0, 16'd7, 1, 0);
    drain();
    send(SUB, 4'd4, 4'd0, 16'd1, 1, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    ref_reset();
    @(negedge clk);
    chk("t6_no_done", done, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ready", cmd_ready, 1);
    chk("t6_psr", psr, 0);
    chk("t6_alu_a", alu_a, 0);
    send(ADD, 4'd4, 4'd0, 16'd0, 1, 0);
    drain();

    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      logic [15:0] imm;
      op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : ops[$urandom_range(0, 12)];
      imm = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20))
                                        : 16'($urandom);
      send(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           imm, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
